reset_sequencer: RTL

- Turns the raw board/bench reset into staged, synchronised reset releases for the standalone MIPS32 system.
- Sits between the clock/reset source and the CPU core, memories and peripherals.
- Release order: memories/peripherals first, CPU core last.
- Also provides a software reset request handshake and reports the cause of the last reset.

---
 rtl/reset_sequencer_pkg.sv | 22 ++
 rtl/reset_sync.sv | 25 ++
 rtl/reset_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer shared types: FSM states, reset causes, sizing helper.
// Watchdog support is selected by RESET_SEQUENCER_WATCHDOG_EN.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN,
    SOFT
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_HARD = 2'b00,
    CAUSE_SOFT = 2'b01,
    CAUSE_WDT  = 2'b10
  } cause_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset deassertion synchroniser: async clear, release after SYNC_STAGES edges.
// sync_next_o is the value sync_done_o takes on the next edge.
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic sync_done_o,
  output logic sync_next_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_done_o = sync_q[SYNC_STAGES-1];
  assign sync_next_o = sync_q[SYNC_STAGES-2];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release with soft-reset handshake and last-cause report.
// Define RESET_SEQUENCER_WATCHDOG_EN to add the RUN-state watchdog.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int STAGE_DELAY = 16,
  parameter int SOFT_HOLD   = 8,
  parameter int WDT_TIMEOUT = 1048576
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soft_req,
  output logic                  soft_ack,
  input  logic                  wdt_kick,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  sys_ready,
  output logic [1:0]            rst_cause
);

  localparam int CW = $clog2(max2(STAGE_DELAY, SOFT_HOLD)) + 1;
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  rdy_q, rdy_d;
  logic                  ack_q, ack_d;
  cause_t                cause_q, cause_d;
  logic                  sync_done;
  logic                  sync_next;
  logic                  wdt_fire;

  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i      (clock),
    .rst_ni     (reset),
    .sync_done_o(sync_done),
    .sync_next_o(sync_next)
  );

`ifdef RESET_SEQUENCER_WATCHDOG_EN
  localparam int WW = $clog2(WDT_TIMEOUT) + 1;

  logic [WW-1:0] wdt_q, wdt_d;

  always_comb begin
    wdt_d    = '0;
    wdt_fire = 1'b0;
    if (state_q == RUN) begin
      if (wdt_kick) begin
        wdt_d = '0;
      end else if (wdt_q == WW'(WDT_TIMEOUT - 1)) begin
        wdt_fire = 1'b1;
      end else begin
        wdt_d = wdt_q + WW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  localparam int unused_wdt_timeout = WDT_TIMEOUT;
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
  assign wdt_fire        = 1'b0;
`endif

  // Leave HOLD on the edge sync_done rises so stage timing counts from it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    ack_d   = 1'b0;
    cause_d = cause_q;
    unique case (state_q)
      HOLD: begin
        if (sync_next | sync_done) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      RELEASE: begin
        if (cnt_q == CW'(STAGE_DELAY - 1)) begin
          cnt_d = '0;
          rst_d = rst_q & ~(NUM_STAGES'(1) << idx_q);
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(NUM_STAGES - 1)) begin
            state_d = RUN;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (wdt_fire || soft_req) begin
          state_d = SOFT;
          cnt_d   = '0;
          rst_d   = '1;
          ack_d   = soft_req;
          cause_d = wdt_fire ? CAUSE_WDT : CAUSE_SOFT;
        end
      end
      SOFT: begin
        if (cnt_q == CW'(SOFT_HOLD - 1)) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = HOLD;
    endcase
    rdy_d = (state_q == RUN) && (state_d == RUN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      rdy_q   <= 1'b0;
      ack_q   <= 1'b0;
      cause_q <= CAUSE_HARD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      rdy_q   <= rdy_d;
      ack_q   <= ack_d;
      cause_q <= cause_d;
    end
  end

  assign rst_out   = rst_q;
  assign sys_ready = rdy_q;
  assign soft_ack  = ack_q;
  assign rst_cause = cause_q;

endmodule
